// File: rtl/imu_pkg.sv
// Shared types and address constants for the IMU master, physics model and SPI responder.
package imu_pkg;

    typedef logic [95:0] data_t;

    localparam logic [6:0]  WHO_AM_I_ADDR    = 7'h0F;
    localparam logic [6:0]  SAMPLE_BASE_ADDR = 7'h22;
    localparam logic [6:0]  CTRL_BASE_ADDR   = 7'h10;
    localparam int unsigned SAMPLE_BYTES     = 12;
    localparam int unsigned CTRL_BYTES       = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDATA,
        WDATA
    } resp_state_t;

    function automatic logic in_window(input logic [6:0] a, input logic [6:0] base,
                                       input int unsigned len);
        return (int'(a) >= int'(base)) && (int'(a) < int'(base) + int'(len));
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin with registered previous-value edge detection.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_imu_responder.sv
// SPI mode-3 slave emulating the IMU: register reads with auto-increment, writes, frozen sample snapshot.
module spi_imu_responder
    import imu_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6C,
    parameter logic [6:0] SAMPLE_BASE  = 7'h22,
    parameter logic [6:0] CTRL_BASE    = 7'h10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       spc,
    input  logic       sdi,
    output logic       sdo,
    input  data_t      sample_data,
    input  logic       sample_valid,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic cs_s, cs_rise, cs_fall;
    logic spc_s, spc_rise_raw, spc_fall_raw;
    logic sdi_s, sdi_rise, sdi_fall;
    logic unused_sdi_edges;
    logic spc_rise, spc_fall;

    spi_pin_sync u_sync_cs  (.clk(clk), .rst_n(rst_n), .pin(cs),  .sync(cs_s),  .rise(cs_rise),      .fall(cs_fall));
    spi_pin_sync u_sync_spc (.clk(clk), .rst_n(rst_n), .pin(spc), .sync(spc_s), .rise(spc_rise_raw), .fall(spc_fall_raw));
    spi_pin_sync u_sync_sdi (.clk(clk), .rst_n(rst_n), .pin(sdi), .sync(sdi_s), .rise(sdi_rise),     .fall(sdi_fall));

    assign unused_sdi_edges = sdi_rise ^ sdi_fall ^ spc_s;
    assign spc_rise = spc_rise_raw & ~cs_s;
    assign spc_fall = spc_fall_raw & ~cs_s;
    assign busy     = ~cs_s;

    resp_state_t state;
    data_t       live;
    data_t       shadow;
    logic [7:0]  ctrl_ram [CTRL_BYTES];
    logic [6:0]  addr;
    logic [5:0]  cmd;
    logic [6:0]  rx;
    logic [7:0]  tx;
    logic [2:0]  bit_cnt;

    logic [7:0]  rd_byte;
    logic [6:0]  sample_off;
    logic [3:0]  ctrl_idx;
    data_t       sample_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= '0;
        end else if (sample_valid) begin
            live <= sample_data;
        end
    end

    always_comb begin
        rd_byte      = '0;
        sample_off   = addr - SAMPLE_BASE;
        ctrl_idx     = 4'(addr - CTRL_BASE);
        sample_shift = shadow >> {sample_off, 3'b000};
        if (addr == WHO_AM_I_ADDR) begin
            rd_byte = WHO_AM_I_VAL;
        end else if (in_window(addr, CTRL_BASE, CTRL_BYTES)) begin
            rd_byte = ctrl_ram[ctrl_idx];
        end else if (in_window(addr, SAMPLE_BASE, SAMPLE_BYTES)) begin
            rd_byte = sample_shift[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sdo       <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            shadow    <= '0;
            addr      <= '0;
            cmd       <= '0;
            rx        <= '0;
            tx        <= '0;
            bit_cnt   <= '0;
            for (int unsigned i = 0; i < CTRL_BYTES; i++) begin
                ctrl_ram[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            // Deselect wins over any edge seen in the same cycle; partial bytes are dropped.
            if (cs_rise) begin
                state   <= IDLE;
                sdo     <= 1'b1;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sdo <= 1'b1;
                        if (cs_fall) begin
                            shadow  <= live;
                            bit_cnt <= '0;
                            state   <= CMD;
                        end
                    end
                    CMD: begin
                        if (spc_rise) begin
                            cmd     <= {cmd[4:0], sdi_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                addr  <= {cmd, sdi_s};
                                state <= rx[6] ? RDATA : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (spc_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd0) begin
                                sdo  <= rd_byte[7];
                                tx   <= {rd_byte[6:0], 1'b0};
                                addr <= addr + 7'd1;
                            end else begin
                                sdo <= tx[7];
                                tx  <= {tx[6:0], 1'b0};
                            end
                        end
                    end
                    WDATA: begin
                        if (spc_rise) begin
                            rx      <= {rx[5:0], sdi_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                                wr_data   <= {rx, sdi_s};
                                if (in_window(addr, CTRL_BASE, CTRL_BYTES)) begin
                                    ctrl_ram[ctrl_idx] <= {rx, sdi_s};
                                end
                                addr <= addr + 7'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // rx doubles as the command MSB tracker while in CMD so rw is available on the 8th rise.
            if (!cs_rise && state == CMD && spc_rise) begin
                rx <= {rx[5:0], sdi_s};
            end
        end
    end

endmodule

// File: tb/tb_spi_imu_responder.sv
// Directed bench for spi_imu_responder: acts as a mode-3 SPI master running at clk/8.
module tb_spi_imu_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        spc = 1'b1;
    logic        sdi = 1'b1;
    logic        sdo;
    logic [95:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [6:0]  seen_addr[$];
    logic [7:0]  seen_data[$];
    logic [7:0]  r;

    spi_imu_responder #(
        .WHO_AM_I_VAL(8'h6C),
        .SAMPLE_BASE (7'h22),
        .CTRL_BASE   (7'h10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .spc         (spc),
        .sdi         (sdi),
        .sdo         (sdo),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            seen_addr.push_back(wr_addr);
            seen_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_txn();
        cs = 1'b0;
        wait_clk(4);
    endtask

    task automatic end_txn();
        spc = 1'b1;
        cs  = 1'b1;
        wait_clk(4);
    endtask

    task automatic xfer(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
        rx = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            spc = 1'b0;
            sdi = tx[7 - i];
            wait_clk(4);
            rx  = {rx[6:0], sdo};
            spc = 1'b1;
            wait_clk(4);
        end
    endtask

    initial begin
        wait_clk(3);
        check("rst_sdo", {31'b0, sdo}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wr_strobe", {31'b0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {25'b0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'b0, wr_data}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        begin_txn();
        check("busy_in_txn", {31'b0, busy}, 32'd1);
        xfer(8'h8F, 8, r);
        xfer(8'h00, 8, r);
        check("who_am_i", {24'b0, r}, 32'h6C);
        end_txn();
        check("sdo_idle", {31'b0, sdo}, 32'd1);
        check("busy_idle", {31'b0, busy}, 32'd0);

        sample_data  = 96'h0B0A09080706050403020100;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        begin_txn();
        xfer(8'hA2, 8, r);
        for (int unsigned k = 0; k < 12; k++) begin
            xfer(8'h00, 8, r);
            check($sformatf("burst_%0d", k), {24'b0, r}, k);
        end
        end_txn();

        begin_txn();
        xfer(8'hA2, 8, r);
        for (int unsigned k = 0; k < 12; k++) begin
            if (k == 3) begin
                sample_data  = {96{1'b1}};
                sample_valid = 1'b1;
                wait_clk(1);
                sample_valid = 1'b0;
            end
            xfer(8'h00, 8, r);
            check($sformatf("coherent_%0d", k), {24'b0, r}, k);
        end
        end_txn();

        begin_txn();
        xfer(8'hA2, 8, r);
        xfer(8'h00, 8, r);
        check("new_snap_0", {24'b0, r}, 32'hFF);
        xfer(8'h00, 8, r);
        check("new_snap_1", {24'b0, r}, 32'hFF);
        end_txn();

        begin_txn();
        xfer(8'hAD, 8, r);
        xfer(8'h00, 8, r);
        check("sample_last", {24'b0, r}, 32'hFF);
        xfer(8'h00, 8, r);
        check("past_sample", {24'b0, r}, 32'h00);
        end_txn();

        begin_txn();
        xfer(8'h10, 8, r);
        xfer(8'h5A, 8, r);
        xfer(8'hA5, 8, r);
        end_txn();
        check("wr_count", seen_addr.size(), 32'd2);
        if (seen_addr.size() == 2) begin
            check("wr_addr0", {25'b0, seen_addr[0]}, 32'h10);
            check("wr_data0", {24'b0, seen_data[0]}, 32'h5A);
            check("wr_addr1", {25'b0, seen_addr[1]}, 32'h11);
            check("wr_data1", {24'b0, seen_data[1]}, 32'hA5);
        end
        begin_txn();
        xfer(8'h90, 8, r);
        xfer(8'h00, 8, r);
        check("ram_rd0", {24'b0, r}, 32'h5A);
        xfer(8'h00, 8, r);
        check("ram_rd1", {24'b0, r}, 32'hA5);
        end_txn();

        begin_txn();
        xfer(8'h10, 8, r);
        xfer(8'h0F, 4, r);
        end_txn();
        check("abort_no_strobe", seen_addr.size(), 32'd2);
        begin_txn();
        xfer(8'h90, 8, r);
        xfer(8'h00, 8, r);
        check("abort_ram_kept", {24'b0, r}, 32'h5A);
        end_txn();
        begin_txn();
        xfer(8'h8F, 8, r);
        xfer(8'h00, 8, r);
        check("abort_who_am_i", {24'b0, r}, 32'h6C);
        end_txn();

        begin_txn();
        xfer(8'hFF, 8, r);
        xfer(8'h00, 8, r);
        check("wrap_rd_7f", {24'b0, r}, 32'h00);
        xfer(8'h00, 8, r);
        check("wrap_rd_00", {24'b0, r}, 32'h00);
        end_txn();
        begin_txn();
        xfer(8'h7F, 8, r);
        xfer(8'h33, 8, r);
        xfer(8'h44, 8, r);
        end_txn();
        check("wrap_wr_count", seen_addr.size(), 32'd4);
        if (seen_addr.size() == 4) begin
            check("wrap_wr_addr0", {25'b0, seen_addr[2]}, 32'h7F);
            check("wrap_wr_addr1", {25'b0, seen_addr[3]}, 32'h00);
            check("wrap_wr_data1", {24'b0, seen_data[3]}, 32'h44);
        end

        begin_txn();
        xfer(8'h90, 8, r);
        spc = 1'b0;
        sdi = 1'b0;
        wait_clk(4);
        check("mid_burst_sdo", {31'b0, sdo}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_sdo", {31'b0, sdo}, 32'd1);
        check("arst_busy", {31'b0, busy}, 32'd0);
        cs  = 1'b1;
        spc = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        begin_txn();
        xfer(8'h90, 8, r);
        xfer(8'h00, 8, r);
        check("ram_cleared", {24'b0, r}, 32'h00);
        end_txn();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
